// File: rtl/t_counter_3bit_pkg.sv
// Shared definitions for the 0-4-7-2-3 sequence counter: state type,
// the main-cycle codes in order, and a small decode helper for consumers.
package t_counter_3bit_pkg;

  typedef logic [2:0] seq_t;

  // Main cycle, in order of appearance after reset release.
  localparam seq_t SEQ_S0  = 3'd0;
  localparam seq_t SEQ_S1  = 3'd4;
  localparam seq_t SEQ_S2  = 3'd7;
  localparam seq_t SEQ_S3  = 3'd2;
  localparam seq_t SEQ_S4  = 3'd3;
  localparam int   SEQ_LEN = 5;

  // True when the code belongs to the main cycle (not one of 1, 5, 6).
  function automatic logic is_main_state(input seq_t s);
    return (s == SEQ_S0) || (s == SEQ_S1) || (s == SEQ_S2) ||
           (s == SEQ_S3) || (s == SEQ_S4);
  endfunction

endpackage

// File: rtl/t_counter_3bit_if.sv
// Output bundle of the sequence counter; the counter drives it, any
// consumer observes it.
interface t_counter_3bit_if;
  import t_counter_3bit_pkg::*;

  seq_t q;

  modport master (output q);
  modport slave  (input  q);

endinterface

// File: rtl/t_counter_3bit_t_ff_sync.sv
// Toggle flip-flop with synchronous active-high reset to 0.
module t_ff_sync (
  input  logic clk,
  input  logic reset,
  input  logic t,
  output logic q
);

  logic r_q;

  // Toggle on t, hold otherwise; reset wins over toggling.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignment so every flop samples pre-edge state.
    if (reset)  r_q <= 1'b0;
    else if (t) r_q <= ~r_q;
  end

  assign q = r_q;

endmodule

// File: rtl/t_counter_3bit.sv
// Free-running 3-bit counter cycling 0 -> 4 -> 7 -> 2 -> 3 -> 0, built from
// three toggle flip-flops; unused codes 1, 5, 6 fall into the cycle in one
// clock.
module t_counter_3bit
  import t_counter_3bit_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  t_counter_3bit_if.master  bus
);

  seq_t w_q;
  logic w_t0;
  logic w_t1;
  logic w_t2;

  // Toggle enables derived from the current state only; no input feeds q
  // combinationally.
  assign w_t0 = w_q[1] | w_q[2];
  assign w_t1 = (w_q[0] & ~w_q[2]) | (w_q[2] & ~w_q[1]);
  assign w_t2 = (~w_q[2] & ~w_q[1]) | (w_q[0] & w_q[2]);

  t_ff_sync u_tff0 (
    .clk   (clk),
    .reset (reset),
    .t     (w_t0),
    .q     (w_q[0])
  );

  t_ff_sync u_tff1 (
    .clk   (clk),
    .reset (reset),
    .t     (w_t1),
    .q     (w_q[1])
  );

  t_ff_sync u_tff2 (
    .clk   (clk),
    .reset (reset),
    .t     (w_t2),
    .q     (w_q[2])
  );

  assign bus.q = w_q;

endmodule

// File: tb/tb_t_counter_3bit.sv
// Bench for t_counter_3bit: scenario tasks against a reference model built
// from the ordered main cycle plus the recovery rules for unused codes.
module tb_t_counter_3bit;
  import t_counter_3bit_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   errors = 0;
  int   checks = 0;
  seq_t exp_q;

  seq_t seq_arr [SEQ_LEN] = '{SEQ_S0, SEQ_S1, SEQ_S2, SEQ_S3, SEQ_S4};

  t_counter_3bit_if bus ();

  t_counter_3bit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  always #5 clk = ~clk;

  // Successor: next element of the ordered cycle, or the recovery target.
  function automatic seq_t model_next(input seq_t s);
    for (int i = 0; i < SEQ_LEN; i++)
      if (seq_arr[i] == s) return seq_arr[(i + 1) % SEQ_LEN];
    case (s)
      3'd1:    return 3'd7;
      3'd5:    return 3'd2;
      3'd6:    return 3'd7;
      default: return 3'bxxx;
    endcase
  endfunction

  // Advance one rising edge and move the model accordingly.
  task automatic tick();
    logic rs;
    @(posedge clk);
    rs = reset;
    #1;
    exp_q = rs ? 3'd0 : model_next(exp_q);
  endtask

  task automatic drive_reset(input logic v);
    @(negedge clk);
    reset = v;
  endtask

  // Run freely until q equals target; bounded, expiry is a failure.
  task automatic run_until(input seq_t target);
    bit found = 0;
    drive_reset(1'b0);
    for (int i = 0; i < 10 && !found; i++) begin
      tick();
      if (bus.q === target) found = 1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL run_until: q=%0d never reached %0d", bus.q, target);
    end
  endtask

  task automatic test_reset();
    drive_reset(1'b1);
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (bus.q !== 3'd0) begin
        errors++;
        $display("FAIL reset edge %0d: q=%0d expected 0", i, bus.q);
      end
    end
  endtask

  task automatic test_free_run();
    drive_reset(1'b0);
    tick();
    checks++;
    if (bus.q !== SEQ_S1) begin
      errors++;
      $display("FAIL first_after_release: q=%0d expected %0d", bus.q, SEQ_S1);
    end
    for (int i = 1; i < 20; i++) begin
      tick();
      checks++;
      if (bus.q !== exp_q || bus.q !== seq_arr[(i + 1) % SEQ_LEN]) begin
        errors++;
        $display("FAIL free_run edge %0d: q=%0d expected %0d", i, bus.q, exp_q);
      end
    end
  endtask

  task automatic test_sync_reset();
    run_until(SEQ_S2);
    @(negedge clk);
    reset = 1'b1;
    #2;
    checks++;
    if (bus.q !== SEQ_S2) begin
      errors++;
      $display("FAIL sync_reset_hold: q=%0d expected %0d", bus.q, SEQ_S2);
    end
    tick();
    checks++;
    if (bus.q !== 3'd0) begin
      errors++;
      $display("FAIL sync_reset_edge: q=%0d expected 0", bus.q);
    end
    drive_reset(1'b0);
    tick();
    checks++;
    if (bus.q !== SEQ_S1) begin
      errors++;
      $display("FAIL sync_reset_release: q=%0d expected %0d", bus.q, SEQ_S1);
    end
    // A pulse that never spans a rising edge must be ignored.
    @(negedge clk);
    reset = 1'b1;
    #2;
    reset = 1'b0;
    tick();
    checks++;
    if (bus.q !== exp_q || bus.q !== SEQ_S2) begin
      errors++;
      $display("FAIL short_pulse: q=%0d expected %0d", bus.q, exp_q);
    end
  endtask

  task automatic test_mid_reset();
    for (int k = 1; k < SEQ_LEN; k++) begin
      run_until(seq_arr[k]);
      drive_reset(1'b1);
      tick();
      checks++;
      if (bus.q !== 3'd0) begin
        errors++;
        $display("FAIL mid_reset from %0d: q=%0d expected 0", seq_arr[k], bus.q);
      end
      drive_reset(1'b0);
      for (int j = 0; j < 2; j++) begin
        tick();
        checks++;
        if (bus.q !== seq_arr[j + 1]) begin
          errors++;
          $display("FAIL mid_resume from %0d step %0d: q=%0d expected %0d",
                   seq_arr[k], j, bus.q, seq_arr[j + 1]);
        end
      end
    end
  endtask

  task automatic test_unused_recovery();
    seq_t unused [3] = '{3'd1, 3'd5, 3'd6};
    seq_t target [3] = '{3'd7, 3'd2, 3'd7};
    for (int k = 0; k < 3; k++) begin
      seq_t s;
      s = unused[k];
      @(negedge clk);
      reset = 1'b0;
      force dut.u_tff0.r_q = s[0];
      force dut.u_tff1.r_q = s[1];
      force dut.u_tff2.r_q = s[2];
      #1;
      release dut.u_tff0.r_q;
      release dut.u_tff1.r_q;
      release dut.u_tff2.r_q;
      exp_q = s;
      #1;
      checks++;
      if (bus.q !== s) begin
        errors++;
        $display("FAIL unused_load %0d: q=%0d expected %0d", s, bus.q, s);
      end
      tick();
      checks++;
      if (bus.q !== target[k] || bus.q !== exp_q) begin
        errors++;
        $display("FAIL unused_recover %0d: q=%0d expected %0d", s, bus.q, target[k]);
      end
      for (int j = 0; j < 5; j++) begin
        tick();
        checks++;
        if (bus.q !== exp_q) begin
          errors++;
          $display("FAIL unused_followon %0d step %0d: q=%0d expected %0d",
                   s, j, bus.q, exp_q);
        end
      end
    end
  endtask

  task automatic test_long_reset();
    run_until(SEQ_S4);
    drive_reset(1'b1);
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if (bus.q !== 3'd0) begin
        errors++;
        $display("FAIL long_reset edge %0d: q=%0d expected 0", i, bus.q);
      end
    end
  endtask

  task automatic test_scoreboard();
    for (int n = 0; n < 100; n++) begin
      int rst_len;
      int run_len;
      rst_len = int'($urandom_range(1, 3));
      run_len = int'($urandom_range(1, 12));
      drive_reset(1'b1);
      for (int i = 0; i < rst_len; i++) begin
        tick();
        checks++;
        if (bus.q !== exp_q) begin
          errors++;
          $display("FAIL score_reset int %0d: q=%0d expected %0d", n, bus.q, exp_q);
        end
      end
      drive_reset(1'b0);
      for (int i = 0; i < run_len; i++) begin
        tick();
        checks++;
        if (bus.q !== exp_q) begin
          errors++;
          $display("FAIL score_run int %0d edge %0d: q=%0d expected %0d",
                   n, i, bus.q, exp_q);
        end
      end
    end
  endtask

  initial begin
    exp_q = 3'd0;
    test_reset();
    test_free_run();
    test_sync_reset();
    test_mid_reset();
    test_unused_recovery();
    test_long_reset();
    test_scoreboard();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
